noc_pe_interface: RTL

NOC_PE_INTERFACE -- requirements
Module: noc_pe_interface

---
 rtl/noc_pkg.sv | 50 +++++
 rtl/ni_sync2.sv | 24 ++
 rtl/noc_pe_interface.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg
// Shared definitions for the NoC PE network interface: packet and payload
// widths, packet field bit offsets, the packed packet layout, the TX/RX
// state encodings and a saturating counter helper.
package noc_pkg;

    localparam int PKT_W     = 57;
    localparam int PAYLOAD_W = 40;
    localparam int COORD_X_W = 3;
    localparam int COORD_Y_W = 2;
    localparam int STAT_W    = 16;

    localparam int PAYLOAD_LSB = 0;
    localparam int YHOP_LSB    = 40;
    localparam int XHOP_LSB    = 42;
    localparam int YDIR_BIT    = 45;
    localparam int XDIR_BIT    = 46;
    localparam int SRCX_LSB    = 47;
    localparam int SRCY_LSB    = 50;
    localparam int PAD_LSB     = 52;

    // Declared MSB first so the packed layout matches the bit offsets above.
    typedef struct packed {
        logic [4:0]           pad;
        logic [COORD_Y_W-1:0] src_y;
        logic [COORD_X_W-1:0] src_x;
        logic                 x_dir;
        logic                 y_dir;
        logic [COORD_X_W-1:0] x_hop;
        logic [COORD_Y_W-1:0] y_hop;
        logic [PAYLOAD_W-1:0] payload;
    } noc_pkt_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_REL  = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_HOLD = 2'd1,
        RX_ACK  = 2'd2
    } rx_state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ni_sync2.sv
// ni_sync2
// Two-flop synchroniser for a single asynchronous level into the clk domain.
// Ports: clk, rst_n (async active-low, clears both flops), d (async level),
//        q (synchronised level, two clk edges of latency).
module ni_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/noc_pe_interface.sv
// noc_pe_interface
// Network interface between a processing element and its mesh router.
// TX: accepts a payload plus destination from the PE, builds a routed
//     packet (hop counts/directions relative to this node) and hands it to
//     the router over a 4-phase req/ack link. Self-addressed payloads are
//     discarded with a one-cycle tx_drop pulse.
// RX: captures packets offered by the router over a 4-phase link and holds
//     them for the PE on a valid/ready interface; ack is only raised once
//     the PE has taken the payload.
// Ports: clk, rst_n; tx_valid/tx_ready/tx_dest_x/tx_dest_y/tx_payload/tx_drop
//        (PE send side); pkt_out_req/pkt_out_ack/pkt_out_data (to router);
//        pkt_in_req/pkt_in_ack/pkt_in_data (from router);
//        rx_valid/rx_ready/rx_payload/rx_src_x/rx_src_y (PE receive side).
// Build option: NI_STATS_EN adds saturating 16-bit tx_count, rx_count and
//        drop_count outputs.
//
// TX FSM
//   state   | meaning
//   TX_IDLE | ready for a PE payload, pkt_out_data may be reloaded
//   TX_REQ  | req high, data frozen, waiting for synchronised ack = 1
//   TX_REL  | req low, waiting for synchronised ack = 0
// RX FSM
//   state   | meaning
//   RX_IDLE | waiting for synchronised req = 1 (once armed)
//   RX_HOLD | packet captured, rx_valid high, waiting for rx_ready
//   RX_ACK  | ack high, waiting for synchronised req = 0
module noc_pe_interface
    import noc_pkg::*;
#(
    parameter int MY_X = 0,
    parameter int MY_Y = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [COORD_X_W-1:0] tx_dest_x,
    input  logic [COORD_Y_W-1:0] tx_dest_y,
    input  logic [PAYLOAD_W-1:0] tx_payload,
    output logic                 tx_drop,
    output logic                 pkt_out_req,
    input  logic                 pkt_out_ack,
    output logic [PKT_W-1:0]     pkt_out_data,
    input  logic                 pkt_in_req,
    output logic                 pkt_in_ack,
    input  logic [PKT_W-1:0]     pkt_in_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [PAYLOAD_W-1:0] rx_payload,
    output logic [COORD_X_W-1:0] rx_src_x,
    output logic [COORD_Y_W-1:0] rx_src_y
`ifdef NI_STATS_EN
    ,
    output logic [STAT_W-1:0]    tx_count,
    output logic [STAT_W-1:0]    rx_count,
    output logic [STAT_W-1:0]    drop_count
`endif
);

    localparam logic [COORD_X_W-1:0] NODE_X = COORD_X_W'(MY_X);
    localparam logic [COORD_Y_W-1:0] NODE_Y = COORD_Y_W'(MY_Y);

    tx_state_t tx_state;
    rx_state_t rx_state;
    noc_pkt_t  tx_pkt;
    noc_pkt_t  out_pkt;
    logic      tx_self;
    logic      ack_sync;
    logic      req_sync;
    logic [1:0] rx_settle;
    logic      rx_armed;

    ni_sync2 u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pkt_out_ack),
        .q     (ack_sync)
    );

    ni_sync2 u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pkt_in_req),
        .q     (req_sync)
    );

    // ---------------------------------------------------------------- TX
    always_comb begin
        tx_pkt         = '0;
        tx_pkt.payload = tx_payload;
        tx_pkt.src_x   = NODE_X;
        tx_pkt.src_y   = NODE_Y;
        tx_pkt.x_dir   = (tx_dest_x > NODE_X);
        tx_pkt.y_dir   = (tx_dest_y > NODE_Y);
        tx_pkt.x_hop   = tx_pkt.x_dir ? (tx_dest_x - NODE_X) : (NODE_X - tx_dest_x);
        tx_pkt.y_hop   = tx_pkt.y_dir ? (tx_dest_y - NODE_Y) : (NODE_Y - tx_dest_y);
    end

    assign tx_self      = (tx_dest_x == NODE_X) && (tx_dest_y == NODE_Y);
    assign tx_ready     = (tx_state == TX_IDLE);
    assign pkt_out_data = out_pkt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            pkt_out_req <= 1'b0;
            tx_drop     <= 1'b0;
            out_pkt     <= '0;
`ifdef NI_STATS_EN
            tx_count    <= '0;
            drop_count  <= '0;
`endif
        end else begin
            tx_drop <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        if (tx_self) begin
                            tx_drop <= 1'b1;
`ifdef NI_STATS_EN
                            drop_count <= sat_inc(drop_count);
`endif
                        end else begin
                            out_pkt     <= tx_pkt;
                            pkt_out_req <= 1'b1;
                            tx_state    <= TX_REQ;
                        end
                    end
                end
                TX_REQ: begin
                    if (ack_sync) begin
                        pkt_out_req <= 1'b0;
                        tx_state    <= TX_REL;
`ifdef NI_STATS_EN
                        tx_count    <= sat_inc(tx_count);
`endif
                    end
                end
                TX_REL: begin
                    if (!ack_sync) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    pkt_out_req <= 1'b0;
                    tx_state    <= TX_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- RX
    // The synchroniser output reads 0 for two edges after reset regardless
    // of the line, so rx_settle masks that window; rx_armed is only set once
    // a genuine low has been observed, which drops a request left high by a
    // transfer that reset interrupted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_settle  <= 2'b00;
            rx_armed   <= 1'b0;
            rx_valid   <= 1'b0;
            pkt_in_ack <= 1'b0;
            rx_payload <= '0;
            rx_src_x   <= '0;
            rx_src_y   <= '0;
`ifdef NI_STATS_EN
            rx_count   <= '0;
`endif
        end else begin
            rx_settle <= {rx_settle[0], 1'b1};
            if (rx_settle[1] && !req_sync) begin
                rx_armed <= 1'b1;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rx_armed && req_sync) begin
                        rx_payload <= pkt_in_data[PAYLOAD_LSB +: PAYLOAD_W];
                        rx_src_x   <= pkt_in_data[SRCX_LSB +: COORD_X_W];
                        rx_src_y   <= pkt_in_data[SRCY_LSB +: COORD_Y_W];
                        rx_valid   <= 1'b1;
                        rx_state   <= RX_HOLD;
                    end
                end
                RX_HOLD: begin
                    if (rx_ready) begin
                        rx_valid   <= 1'b0;
                        pkt_in_ack <= 1'b1;
                        rx_state   <= RX_ACK;
`ifdef NI_STATS_EN
                        rx_count   <= sat_inc(rx_count);
`endif
                    end
                end
                RX_ACK: begin
                    if (!req_sync) begin
                        pkt_in_ack <= 1'b0;
                        rx_state   <= RX_IDLE;
                    end
                end
                default: begin
                    rx_valid   <= 1'b0;
                    pkt_in_ack <= 1'b0;
                    rx_state   <= RX_IDLE;
                end
            endcase
        end
    end

    // Routing fields of an arriving packet are meaningless at the destination.
    logic unused_pkt_bits;
    assign unused_pkt_bits = ^{pkt_in_data[PKT_W-1:PAD_LSB],
                               pkt_in_data[XDIR_BIT:YHOP_LSB]};

endmodule
